// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding
// and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset load, sequential/branch next-PC selection
// with word alignment, and the architectural R15 read value (PC+8).
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_pc_src,
  input  logic [31:0] i_result,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus8
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Branch targets are forced onto a word boundary; arithmetic wraps mod 2^32.
  assign w_pc_next = i_pc_src ? (i_result & ~32'h0000_0003) : (r_pc + PC_STEP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus8 = r_pc + (PC_STEP << 1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/valid handshake, holds the
// instruction until retired, and traps to ERROR if memory never answers.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        Advance,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        FetchErr
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [15:0]  r_wdog;
  logic [15:0]  w_wdog_next;
  logic [31:0]  r_instr;
  logic         w_capture;
  logic         w_pc_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= BOOT;
      r_wdog  <= 16'd0;
      r_instr <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_wdog  <= w_wdog_next;
      if (w_capture) begin
        r_instr <= ImemRdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wdog_next  = r_wdog;
    w_capture    = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        // A response in the same cycle the count expires still wins.
        if (ImemValid) begin
          w_capture    = 1'b1;
          w_wdog_next  = 16'd0;
          w_state_next = ISSUE;
        end else if (r_wdog == TIMEOUT_CNT) begin
          w_state_next = ERROR;
        end else begin
          w_wdog_next = r_wdog + 16'd1;
        end
      end
      ISSUE: begin
        if (Advance) begin
          w_pc_load    = 1'b1;
          w_state_next = FETCH;
        end
      end
      ERROR: begin
        w_state_next = ERROR;
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_pc_load),
    .i_pc_src   (PCSrc),
    .i_result   (Result),
    .o_pc       (PC),
    .o_pc_plus8 (PCPlus8)
  );

  assign ImemReq    = (r_state == FETCH);
  assign InstrValid = (r_state == ISSUE);
  assign FetchErr   = (r_state == ERROR);
  assign ImemAddr   = PC;
  assign Instr      = r_instr;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the controller and datapath. Owns the program counter, fetches 32-bit instructions from instruction memory over a request/valid handshake, and holds each instruction stable on `Instr` until the core retires it. On retire it selects the next PC (PC+4 or the branch/`R15` write result under `PCSrc`). A watchdog flags instruction memory that never responds.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; word aligned.
- `TIMEOUT`, default 255: maximum cycles `ImemReq` may stay high without `ImemValid` before error; 1..65535.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `PCSrc`  in  1  from controller; 1 = next PC comes from `Result`.
- `Result`  in  32  branch target / `R15` write value from the datapath.
- `Advance`  in  1  core finished executing the current instruction; meaningful only while `InstrValid`=1.
- `ImemReq`  out  1  fetch request; held high until the response arrives.
- `ImemAddr`  out  32  fetch address; equals `PC` and is stable while `ImemReq`=1.
- `ImemRdata`  in  32  instruction word; sampled when `ImemValid`=1.
- `ImemValid`  in  1  single-cycle response strobe; may arrive in the same cycle as `ImemReq` rises.
- `Instr`  out  32  registered instruction to controller and datapath.
- `InstrValid`  out  1  `Instr` is valid and the core may execute it.
- `PC`  out  32  address of `Instr`.
- `PCPlus8`  out  32  `PC`+8, the architectural `R15` read value.
- `FetchErr`  out  1  sticky timeout flag.

## Operation
- States: BOOT, FETCH, ISSUE, ERROR.
- BOOT: one cycle after reset release; `ImemReq`=0. Moves to FETCH.
- FETCH: `ImemReq`=1, `ImemAddr`=`PC`. On `ImemValid`, `Instr`<=`ImemRdata`, clear the watchdog, go to ISSUE. Otherwise increment the watchdog. When the watchdog reaches `TIMEOUT`, go to ERROR.
- ISSUE: `InstrValid`=1, `ImemReq`=0. On `Advance`, `PC`<= `PCSrc` ? {`Result`[31:2],2'b00} : `PC`+4 (mod 2^32), then go to FETCH. Without `Advance`, `Instr` and `PC` hold.
- ERROR: `FetchErr`=1, `ImemReq`=0, `InstrValid`=0. Only `reset` leaves this state.
- `ImemValid` outside FETCH is ignored. `Advance` outside ISSUE is ignored.
- PC arithmetic wraps: 32'hFFFF_FFFC+4 = 0.
- `Result` bits [1:0] are always discarded.

## Timing
- Reset values: state BOOT, `PC`=`RESET_PC`, `Instr`=0, `InstrValid`=0, `ImemReq`=0, `FetchErr`=0, watchdog=0, `PCPlus8`=`RESET_PC`+8.
- `ImemReq` and `InstrValid` are decoded from state only. `ImemAddr` and `PCPlus8` are derived from `PC` only.
- With a zero-wait memory (`ImemValid` in the cycle `ImemReq` rises), each instruction takes 2 cycles: FETCH then ISSUE. Each memory wait cycle adds one cycle.
- `Advance` sampled high in ISSUE: the new `PC` is visible the next cycle, and `InstrValid` is low for at least one cycle.
- Reset asserted in any state, including mid-FETCH: on that edge return to BOOT with the reset values. A late `ImemValid` after reset is ignored because BOOT ignores it.
- Watchdog: `FetchErr` rises on the edge where the count reaches `TIMEOUT`. This is cycle `TIMEOUT`+1 of FETCH.

## Structure
- A shared package `fetch_pkg` holds the state typedef (`fetch_state_t`: BOOT, FETCH, ISSUE, ERROR) and the constant `PC_STEP`=4.
- A natural sub-module is `pc_reg`: the PC register with reset load, PC+4/`Result` selection, alignment masking, and the `PCPlus8` adder.
- The FSM and the watchdog live in the top module.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning 32'hE3A0_1005, `Advance` held high -> `ImemAddr` sequence 0,4,8 at two cycles each; `Instr`=32'hE3A0_1005 with `InstrValid` in every ISSUE cycle; `PCPlus8`=8 at `PC`=0.
- In ISSUE at `PC`=8: `PCSrc`=1, `Result`=32'h0000_0103, `Advance`=1 -> next `ImemAddr`=32'h100.
- Memory with 3 wait cycles, `Advance` low for 5 cycles in ISSUE -> `ImemReq` high for 4 cycles with stable address; `Instr` and `PC` unchanged until `Advance`.
- `TIMEOUT`=4, memory never responds -> `FetchErr` rises after 5 FETCH cycles, `ImemReq` falls, and the block stays in ERROR until reset.
- Reset asserted during the FETCH wait, `ImemValid` arriving one cycle later -> `PC`=`RESET_PC`, `InstrValid`=0, and the stale data is not captured.
- `PC`=32'hFFFF_FFFC, `Advance` with `PCSrc`=0 -> next `ImemAddr`=0.
